conv_bram_1d_ctrl: RTL and testbench

Sequencer for the 1D BRAM convolution datapath. On a start pulse it streams image columns 0..IMG_W-1 from the image RAM, one column per cycle. It drives the datapath's shift-register enable, result write address and result write enable. It then waits for the datapath's last_val and reports completion with a done pulse. It sits between the host/top-level FSM, the image RAM read port and the datapath.

---
 rtl/conv_1d_pkg.sv | 34 +++
 rtl/conv_1d_window_tracker.sv | 73 +++++++
 rtl/conv_bram_1d_ctrl.sv | 140 ++++++++++++++
 tb/tb_conv_bram_1d_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_1d_pkg.sv
// conv_1d_pkg: shared types and helpers for the 1D convolution controller.
// Holds the FSM state type, the result-width function and address-width helpers.
package conv_1d_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } ctrl_state_t;

  localparam int PERF_W = 32;

  function automatic int result_w(
    input int img_w,
    input int filt_l,
    input int stride_w
  );
    return (img_w - filt_l) / stride_w + 1;
  endfunction

  // Never returns 0 so that single-entry ranges still get a 1-bit register.
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_IMG_W    = 32;
  localparam int DEF_FILTER_L = 3;
  localparam int DEF_STRIDE_W = 1;
  localparam int DEF_IMG_AW   = addr_w(DEF_IMG_W);
  localparam int DEF_RES_AW   =
    addr_w(result_w(DEF_IMG_W, DEF_FILTER_L, DEF_STRIDE_W));

endpackage

// File: rtl/conv_1d_window_tracker.sv
// conv_1d_window_tracker: counts shifted columns, spots complete windows.
// In: clk, reset (sync, active-low), clear, sr_wren. Out: result_wren, result_wraddr.
module conv_1d_window_tracker
  import conv_1d_pkg::*;
#(
  parameter int IMG_W    = 32,
  parameter int FILTER_L = 3,
  parameter int STRIDE_W = 1,
  parameter int RESULT_W = 30,
  parameter int CW       = 5,
  parameter int RW       = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          sr_wren,
  output logic          result_wren,
  output logic [RW-1:0] result_wraddr
);

  localparam int PW = addr_w(STRIDE_W);

  localparam logic [CW-1:0] FIRST_WIN = CW'(FILTER_L - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_W - 1);
  localparam logic [PW-1:0] LAST_PH   = PW'(STRIDE_W - 1);
  localparam logic [RW-1:0] LAST_RES  = RW'(RESULT_W - 1);

  logic [CW-1:0] sh_col;
  logic [PW-1:0] phase;
  logic [RW-1:0] res_idx;
  logic          filled;
  logic          win_ok;

  // Phase only advances once the first full window exists, so phase 0
  // marks every STRIDE_W-th column from column FILTER_L-1 onward.
  always_comb begin
    filled = (sh_col >= FIRST_WIN);
    win_ok = sr_wren && filled && (phase == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sh_col        <= '0;
      phase         <= '0;
      res_idx       <= '0;
      result_wren   <= 1'b0;
      result_wraddr <= '0;
    end else if (clear) begin
      sh_col        <= '0;
      phase         <= '0;
      res_idx       <= '0;
      result_wren   <= 1'b0;
      result_wraddr <= '0;
    end else begin
      result_wren <= win_ok;
      if (sr_wren) begin
        if (sh_col != LAST_COL) begin
          sh_col <= sh_col + 1'b1;
        end
        if (filled) begin
          phase <= (phase == LAST_PH) ? '0 : phase + 1'b1;
        end
      end
      if (win_ok) begin
        result_wraddr <= res_idx;
        if (res_idx != LAST_RES) begin
          res_idx <= res_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/conv_bram_1d_ctrl.sv
// conv_bram_1d_ctrl: sequencer for the 1D BRAM convolution datapath.
// Ports: clk, reset (sync, active-low); start/busy/done host handshake;
// img_rdaddr/img_rden image RAM read; dpath_sr_wren, dpath_result_wraddr,
// dpath_result_wren to datapath; last_val from datapath. Optional
// perf_cycles [31:0] when CONV_1D_CTRL_PERF_EN is defined.
module conv_bram_1d_ctrl
  import conv_1d_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 32,
  parameter int FILTER_L   = 3,
  parameter int STRIDE_W   = 1,
  parameter int RAM_RD_LAT = 1,
  localparam int RESULT_W  = result_w(IMG_W, FILTER_L, STRIDE_W),
  localparam int IMG_RAM_ADDR_WIDTH    = addr_w(IMG_W),
  localparam int RESULT_RAM_ADDR_WIDTH = addr_w(RESULT_W)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic [IMG_RAM_ADDR_WIDTH-1:0]    img_rdaddr,
  output logic                             img_rden,
  output logic                             dpath_sr_wren,
  output logic [RESULT_RAM_ADDR_WIDTH-1:0] dpath_result_wraddr,
  output logic                             dpath_result_wren,
  input  logic                             last_val
`ifdef CONV_1D_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]                perf_cycles
`endif
);

  localparam logic [IMG_RAM_ADDR_WIDTH-1:0] LAST_COL =
    IMG_RAM_ADDR_WIDTH'(IMG_W - 1);

  if (DATA_WIDTH < 1 || STRIDE_W < 1 || RAM_RD_LAT < 1 ||
      FILTER_L < 1 || FILTER_L > IMG_W) begin : g_bad_cfg
    $error("conv_bram_1d_ctrl: illegal parameter set");
  end

  ctrl_state_t state;
  ctrl_state_t state_n;

  logic [IMG_RAM_ADDR_WIDTH-1:0] rd_col;
  logic [RAM_RD_LAT-1:0]         vld_pipe;

  logic accept;
  logic rden_d;
  logic busy_d;
  logic done_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = READ;
      READ:    if (rd_col == LAST_COL) state_n = DRAIN;
      DRAIN:   if (last_val) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered, so they trail the state by one cycle:
  // the read for column c leaves the block in cycle 1+c.
  always_comb begin
    accept = (state == IDLE) && start;
    rden_d = (state == READ);
    busy_d = (state == READ) || (state == DRAIN);
    done_d = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      img_rden   <= 1'b0;
      img_rdaddr <= '0;
      rd_col     <= '0;
      vld_pipe   <= '0;
    end else begin
      busy        <= busy_d;
      done        <= done_d;
      img_rden    <= rden_d;
      vld_pipe[0] <= img_rden;
      for (int i = 1; i < RAM_RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
      if (accept) begin
        rd_col <= '0;
      end else if (rden_d) begin
        img_rdaddr <= rd_col;
        if (rd_col != LAST_COL) begin
          rd_col <= rd_col + 1'b1;
        end
      end
    end
  end

  // Read data lands RAM_RD_LAT cycles after the enable.
  assign dpath_sr_wren = vld_pipe[RAM_RD_LAT-1];

  conv_1d_window_tracker #(
    .IMG_W    (IMG_W),
    .FILTER_L (FILTER_L),
    .STRIDE_W (STRIDE_W),
    .RESULT_W (RESULT_W),
    .CW       (IMG_RAM_ADDR_WIDTH),
    .RW       (RESULT_RAM_ADDR_WIDTH)
  ) u_win (
    .clk           (clk),
    .reset         (reset),
    .clear         (accept),
    .sr_wren       (dpath_sr_wren),
    .result_wren   (dpath_result_wren),
    .result_wraddr (dpath_result_wraddr)
  );

`ifdef CONV_1D_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_cycles <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
    end else if (state != IDLE) begin
      perf_cycles <= perf_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_bram_1d_ctrl.sv
// tb_conv_bram_1d_ctrl: directed bench for conv_bram_1d_ctrl.
// Three instances: defaults, STRIDE_W=2, RAM_RD_LAT=3, sharing inputs.
module tb_conv_bram_1d_ctrl;

  localparam int N = 48;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic last_val = 1'b0;

  always #5 clk = ~clk;

  logic       busy_a, done_a, rden_a, sr_a, rw_a;
  logic [4:0] addr_a, rwa_a;
  logic       busy_b, done_b, rden_b, sr_b, rw_b;
  logic [4:0] addr_b;
  logic [3:0] rwa_b;
  logic       busy_c, done_c, rden_c, sr_c, rw_c;
  logic [4:0] addr_c, rwa_c;
`ifdef CONV_1D_CTRL_PERF_EN
  logic [31:0] perf_a, perf_b, perf_c;
`endif

  conv_bram_1d_ctrl u_def (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy_a), .done(done_a),
    .img_rdaddr(addr_a), .img_rden(rden_a),
    .dpath_sr_wren(sr_a),
    .dpath_result_wraddr(rwa_a),
    .dpath_result_wren(rw_a),
    .last_val(last_val)
`ifdef CONV_1D_CTRL_PERF_EN
    , .perf_cycles(perf_a)
`endif
  );

  conv_bram_1d_ctrl #(.STRIDE_W(2)) u_s2 (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy_b), .done(done_b),
    .img_rdaddr(addr_b), .img_rden(rden_b),
    .dpath_sr_wren(sr_b),
    .dpath_result_wraddr(rwa_b),
    .dpath_result_wren(rw_b),
    .last_val(last_val)
`ifdef CONV_1D_CTRL_PERF_EN
    , .perf_cycles(perf_b)
`endif
  );

  conv_bram_1d_ctrl #(.RAM_RD_LAT(3)) u_l3 (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy_c), .done(done_c),
    .img_rdaddr(addr_c), .img_rden(rden_c),
    .dpath_sr_wren(sr_c),
    .dpath_result_wraddr(rwa_c),
    .dpath_result_wren(rw_c),
    .last_val(last_val)
`ifdef CONV_1D_CTRL_PERF_EN
    , .perf_cycles(perf_c)
`endif
  );

  logic       c_busy[N], c_done[N], c_rden[N], c_sr[N], c_rw[N];
  logic [4:0] c_addr[N], c_rwa[N];
  logic       c_rw2[N];
  logic [3:0] c_rwa2[N];
  logic       c_rden3[N], c_sr3[N], c_rw3[N];
  logic [4:0] c_addr3[N], c_rwa3[N];
`ifdef CONV_1D_CTRL_PERF_EN
  logic [31:0] c_perf[N];
`endif

  int checks = 0;
  int fails  = 0;

  // One run: start sampled at edge 0, last_val sampled at edge lv,
  // reset low at edge rst_at (-1 = none). inject adds stray start and
  // last_val pulses. Outputs captured 1ns after each edge k.
  task automatic run(input int lv, input int rst_at, input bit inject);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      start    = (k == 0) || (inject && (k == 10 || k == 38));
      last_val = (k == lv) || (inject && k == 20);
      reset    = !(k == rst_at);
      @(posedge clk);
      #1;
      c_busy[k]  = busy_a;
      c_done[k]  = done_a;
      c_rden[k]  = rden_a;
      c_addr[k]  = addr_a;
      c_sr[k]    = sr_a;
      c_rw[k]    = rw_a;
      c_rwa[k]   = rwa_a;
      c_rw2[k]   = rw_b;
      c_rwa2[k]  = rwa_b;
      c_rden3[k] = rden_c;
      c_addr3[k] = addr_c;
      c_sr3[k]   = sr_c;
      c_rw3[k]   = rw_c;
      c_rwa3[k]  = rwa_c;
`ifdef CONV_1D_CTRL_PERF_EN
      c_perf[k]  = perf_a;
`endif
    end
    @(negedge clk);
    start    = 1'b0;
    last_val = 1'b0;
    reset    = 1'b1;
  endtask

  task automatic verify_default_run(input string tag);
    logic e;
    int   ndone;
    ndone = 0;
    for (int k = 0; k < N; k++) begin
      e = (k >= 1 && k <= 32);
      checks++;
      if (c_rden[k] !== e) begin
        fails++;
        $display("FAIL %s rden k=%0d got %0b want %0b", tag, k, c_rden[k], e);
      end
      if (e) begin
        checks++;
        if (c_addr[k] !== 5'(k - 1)) begin
          fails++;
          $display("FAIL %s addr k=%0d got %0d want %0d", tag, k, c_addr[k], k - 1);
        end
      end
      e = (k >= 2 && k <= 33);
      checks++;
      if (c_sr[k] !== e) begin
        fails++;
        $display("FAIL %s sr_wren k=%0d got %0b want %0b", tag, k, c_sr[k], e);
      end
      e = (k >= 5 && k <= 34);
      checks++;
      if (c_rw[k] !== e) begin
        fails++;
        $display("FAIL %s res_wren k=%0d got %0b want %0b", tag, k, c_rw[k], e);
      end
      if (e) begin
        checks++;
        if (c_rwa[k] !== 5'(k - 5)) begin
          fails++;
          $display("FAIL %s res_addr k=%0d got %0d want %0d", tag, k, c_rwa[k], k - 5);
        end
      end
      e = (k >= 1 && k <= 40);
      checks++;
      if (c_busy[k] !== e) begin
        fails++;
        $display("FAIL %s busy k=%0d got %0b want %0b", tag, k, c_busy[k], e);
      end
      e = (k == 41);
      checks++;
      if (c_done[k] !== e) begin
        fails++;
        $display("FAIL %s done k=%0d got %0b want %0b", tag, k, c_done[k], e);
      end
      if (c_done[k] === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 1) begin
      fails++;
      $display("FAIL %s done_count got %0d want 1", tag, ndone);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if ({busy_a, done_a, rden_a, sr_a, rw_a, addr_a, rwa_a} !== '0) begin
        fails++;
        $display("FAIL reset def got %b want 0",
                 {busy_a, done_a, rden_a, sr_a, rw_a, addr_a, rwa_a});
      end
      checks++;
      if ({busy_b, rw_b, rwa_b, busy_c, sr_c, rw_c, addr_c} !== '0) begin
        fails++;
        $display("FAIL reset s2_l3 got %b want 0",
                 {busy_b, rw_b, rwa_b, busy_c, sr_c, rw_c, addr_c});
      end
`ifdef CONV_1D_CTRL_PERF_EN
      checks++;
      if (perf_a !== 32'd0) begin
        fails++;
        $display("FAIL reset perf got %0d want 0", perf_a);
      end
`endif
    end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_default();
    run(40, -1, 1'b0);
    verify_default_run("default");
  endtask

  task automatic test_stride2();
    logic e;
    int   n;
    run(40, -1, 1'b0);
    n = 0;
    for (int k = 0; k < N; k++) begin
      e = (k >= 5 && k <= 33 && ((k - 5) % 2 == 0));
      checks++;
      if (c_rw2[k] !== e) begin
        fails++;
        $display("FAIL stride2 res_wren k=%0d got %0b want %0b", k, c_rw2[k], e);
      end
      if (e) begin
        checks++;
        if (c_rwa2[k] !== 4'((k - 5) / 2)) begin
          fails++;
          $display("FAIL stride2 res_addr k=%0d got %0d want %0d",
                   k, c_rwa2[k], (k - 5) / 2);
        end
      end
      if (c_rw2[k] === 1'b1) n++;
    end
    checks++;
    if (n !== 15) begin
      fails++;
      $display("FAIL stride2 count got %0d want 15", n);
    end
  endtask

  task automatic test_latency3();
    logic e;
    run(40, -1, 1'b0);
    for (int k = 0; k < N; k++) begin
      e = (k >= 1 && k <= 32);
      checks++;
      if (c_rden3[k] !== e) begin
        fails++;
        $display("FAIL lat3 rden k=%0d got %0b want %0b", k, c_rden3[k], e);
      end
      if (e) begin
        checks++;
        if (c_addr3[k] !== 5'(k - 1)) begin
          fails++;
          $display("FAIL lat3 addr k=%0d got %0d want %0d", k, c_addr3[k], k - 1);
        end
      end
      e = (k >= 4 && k <= 35);
      checks++;
      if (c_sr3[k] !== e) begin
        fails++;
        $display("FAIL lat3 sr_wren k=%0d got %0b want %0b", k, c_sr3[k], e);
      end
      e = (k >= 7 && k <= 36);
      checks++;
      if (c_rw3[k] !== e) begin
        fails++;
        $display("FAIL lat3 res_wren k=%0d got %0b want %0b", k, c_rw3[k], e);
      end
      if (e) begin
        checks++;
        if (c_rwa3[k] !== 5'(k - 7)) begin
          fails++;
          $display("FAIL lat3 res_addr k=%0d got %0d want %0d", k, c_rwa3[k], k - 7);
        end
      end
    end
  endtask

  task automatic test_ignored_inputs();
    // last_val while idle must not produce a done.
    @(negedge clk);
    last_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    last_val = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
        fails++;
        $display("FAIL idle_last_val done/busy got %0b%0b want 00", done_a, busy_a);
      end
    end
    run(40, -1, 1'b1);
    verify_default_run("ignored");
  endtask

  task automatic test_reset_mid_run();
    run(40, 10, 1'b0);
    for (int k = 10; k <= 11; k++) begin
      checks++;
      if ({c_busy[k], c_done[k], c_rden[k], c_sr[k], c_rw[k], c_addr[k], c_rwa[k]} !== '0) begin
        fails++;
        $display("FAIL midreset outputs k=%0d got %b want 0", k,
                 {c_busy[k], c_done[k], c_rden[k], c_sr[k], c_rw[k], c_addr[k], c_rwa[k]});
      end
      checks++;
      if ({c_sr3[k], c_rw3[k], c_rw2[k]} !== 3'b000) begin
        fails++;
        $display("FAIL midreset others k=%0d got %b want 000", k,
                 {c_sr3[k], c_rw3[k], c_rw2[k]});
      end
    end
    for (int k = 10; k < N; k++) begin
      checks++;
      if (c_done[k] !== 1'b0) begin
        fails++;
        $display("FAIL midreset done k=%0d got %0b want 0", k, c_done[k]);
      end
    end
    run(40, -1, 1'b0);
    verify_default_run("after_reset");
  endtask

  task automatic test_back_to_back();
    run(40, -1, 1'b0);
    verify_default_run("b2b_first");
    run(40, -1, 1'b0);
    verify_default_run("b2b_second");
  endtask

`ifdef CONV_1D_CTRL_PERF_EN
  task automatic test_perf();
    run(40, -1, 1'b0);
    checks++;
    if (c_perf[0] !== 32'd0) begin
      fails++;
      $display("FAIL perf clear got %0d want 0", c_perf[0]);
    end
    checks++;
    if (c_perf[10] !== 32'd10) begin
      fails++;
      $display("FAIL perf mid got %0d want 10", c_perf[10]);
    end
    for (int k = 41; k < N; k++) begin
      checks++;
      if (c_perf[k] !== 32'd41) begin
        fails++;
        $display("FAIL perf final k=%0d got %0d want 41", k, c_perf[k]);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (perf_a !== 32'd41) begin
      fails++;
      $display("FAIL perf hold got %0d want 41", perf_a);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default();
    test_stride2();
    test_latency3();
    test_ignored_inputs();
    test_reset_mid_run();
    test_back_to_back();
`ifdef CONV_1D_CTRL_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
